seg7_scan_mux: RTL and testbench

Multiplexed driver for an NDIG-digit common-anode/cathode 7-segment display, generalising the single-digit hex-to-segment decoder to a scanned multi-digit display with per-digit decimal points. A free-running prescaler advances a digit scan. Host writes are double-buffered and committed only at a frame boundary, so no digit ever shows a torn value. It sits between board-level logic (counters, status) and the display pins.

---
 rtl/seg7_pkg.sv | 16 +
 rtl/seg7_hex_decode.sv | 14 +
 rtl/seg7_scan_mux.sv | 111 +++++++++++
 tb/tb_seg7_scan_mux.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: bit order {g,f,e,d,c,b,a}, the hex glyph table and the blank pattern.
package seg7_pkg;

  typedef struct packed {
    logic g, f, e, d, c, b, a;
  } seg_t;

  localparam logic [6:0] SEG_OFF = 7'h00;

  // Entry n is the glyph for hex digit n.
  localparam logic [15:0][6:0] SEG_HEX = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-high {g,f,e,d,c,b,a} segment pattern.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  seg_t pat;

  assign pat = SEG_HEX[nib];
  assign seg = pat;

endmodule

// File: rtl/seg7_scan_mux.sv
// Scanned NDIG-digit 7-segment driver with frame-aligned double-buffered loads.
// Define SEG7_LZB_EN to blank leading zero digits (digit 0 always shows).
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int NDIG       = 4,
  parameter int PRESC_BITS = 16,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_load,
  input  logic [4*NDIG-1:0]   i_val,
  input  logic [NDIG-1:0]     i_dp,
  output logic [6:0]          o_seg,
  output logic                o_dp,
  output logic [NDIG-1:0]     o_an,
  output logic                o_pending,
  output logic                o_frame
);

  localparam int              IW      = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [6:0]      SEG_POL = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [NDIG-1:0] AN_POL  = (ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic            DP_POL  = (ACTIVE_LOW != 0);

  logic [PRESC_BITS-1:0]  presc;
  logic [IW-1:0]          idx;
  logic                   tick, last, boundary;
  logic [NDIG-1:0][3:0]   act_val, pend_val;
  logic [NDIG-1:0]        act_dp, pend_dp;
  logic [NDIG-1:0][6:0]   dig_seg;
  logic [1:0]             frm_pipe;

  assign tick     = &presc;
  assign last     = (idx == IW'(NDIG - 1));
  assign boundary = tick && last;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      presc <= '0;
      idx   <= '0;
    end else begin
      presc <= presc + 1'b1;
      if (tick) idx <= last ? '0 : idx + 1'b1;
    end
  end

  // A load landing on the boundary edge goes straight to the active buffer.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      act_val   <= '0;
      act_dp    <= '0;
      pend_val  <= '0;
      pend_dp   <= '0;
      o_pending <= 1'b0;
    end else if (boundary) begin
      if (i_load) begin
        act_val <= i_val;
        act_dp  <= i_dp;
      end else if (o_pending) begin
        act_val <= pend_val;
        act_dp  <= pend_dp;
      end
      o_pending <= 1'b0;
    end else if (i_load) begin
      pend_val  <= i_val;
      pend_dp   <= i_dp;
      o_pending <= 1'b1;
    end
  end

  for (genvar k = 0; k < NDIG; k++) begin : g_dig
    logic [6:0] pat;

    seg7_hex_decode u_dec (
      .nib (act_val[k]),
      .seg (pat)
    );

`ifdef SEG7_LZB_EN
    logic nz;  // this digit or any more significant one is nonzero
    if (k == NDIG - 1) begin : g_msd
      assign nz = |act_val[k];
    end else begin : g_lsd
      assign nz = (|act_val[k]) | g_dig[k+1].nz;
    end
    assign dig_seg[k] = (k == 0 || nz) ? pat : SEG_OFF;
`else
    assign dig_seg[k] = pat;
`endif
  end

  // Output registers add one cycle, so the frame pulse is delayed twice to line up with digit 0.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_seg    <= SEG_OFF ^ SEG_POL;
      o_dp     <= DP_POL;
      o_an     <= AN_POL;
      frm_pipe <= '0;
    end else begin
      o_seg    <= dig_seg[idx] ^ SEG_POL;
      o_dp     <= act_dp[idx] ^ DP_POL;
      o_an     <= (NDIG'(1) << idx) ^ AN_POL;
      frm_pipe <= {frm_pipe[0], boundary};
    end
  end

  assign o_frame = frm_pipe[1];

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Directed scoreboard bench for seg7_scan_mux (NDIG=4, PRESC_BITS=2), active-high and active-low instances.
module tb_seg7_scan_mux;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load;
  logic [15:0] val;
  logic [3:0]  dpi;
  logic [6:0]  seg, seg_n;
  logic        dpo, dpo_n, pend, pend_n, frm, frm_n;
  logic [3:0]  an, an_n;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  seg7_scan_mux #(.NDIG(4), .PRESC_BITS(2), .ACTIVE_LOW(0)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_load(load), .i_val(val), .i_dp(dpi),
    .o_seg(seg), .o_dp(dpo), .o_an(an), .o_pending(pend), .o_frame(frm)
  );

  seg7_scan_mux #(.NDIG(4), .PRESC_BITS(2), .ACTIVE_LOW(1)) dut_n (
    .i_clk(clk), .i_rst_n(rst_n), .i_load(load), .i_val(val), .i_dp(dpi),
    .o_seg(seg_n), .o_dp(dpo_n), .o_an(an_n), .o_pending(pend_n), .o_frame(frm_n)
  );

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F; 4'h1: return 7'h06; 4'h2: return 7'h5B; 4'h3: return 7'h4F;
      4'h4: return 7'h66; 4'h5: return 7'h6D; 4'h6: return 7'h7D; 4'h7: return 7'h07;
      4'h8: return 7'h7F; 4'h9: return 7'h6F; 4'hA: return 7'h77; 4'hB: return 7'h7C;
      4'hC: return 7'h39; 4'hD: return 7'h5E; 4'hE: return 7'h79; default: return 7'h71;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input logic [15:0] v, input int k);
`ifdef SEG7_LZB_EN
    logic [15:0] hi;
    hi = v >> (4 * k);
    if (k != 0 && hi == 16'h0) return 7'h00;
`endif
    return hex7(v[4*k +: 4]);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_pins(input string tag, input logic [6:0] s, input logic d, input logic [3:0] a);
    logic [6:0] si;
    logic       di;
    logic [3:0] ai;
    si = ~s; di = ~d; ai = ~a;
    chk({tag, " seg"},   seg,   s);
    chk({tag, " dp"},    dpo,   d);
    chk({tag, " an"},    an,    a);
    chk({tag, " seg_n"}, seg_n, si);
    chk({tag, " dp_n"},  dpo_n, di);
    chk({tag, " an_n"},  an_n,  ai);
  endtask

  task automatic chk_pend(input string tag, input logic p);
    chk({tag, " pending"},   pend,   p);
    chk({tag, " pending_n"}, pend_n, p);
  endtask

  task automatic push_frame(input logic [15:0] v, input logic [3:0] d);
    for (int k = 0; k < 4; k++) sb.push_back('{seg: exp_seg(v, k), dp: d[k], an: 4'b0001 << k});
  endtask

  task automatic wait_frame(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frm !== 1'b1 && n < 40);
    chk({tag, " frame"}, frm, 1'b1);
  endtask

  // Called at a frame-start sample; compares every cycle of the frame and ends at the next frame start.
  task automatic check_frame(input string tag);
    exp_t e;
    for (int d = 0; d < 4; d++) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s: scoreboard empty at digit %0d", tag, d);
        return;
      end
      e = sb.pop_front();
      for (int j = 0; j < 4; j++) begin
        check_pins($sformatf("%s d%0d", tag, d), e.seg, e.dp, e.an);
        @(negedge clk);
      end
    end
    chk({tag, " next frame"},   frm,   1'b1);
    chk({tag, " next frame_n"}, frm_n, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b0; val = '0; dpi = '0;
    repeat (3) @(negedge clk);
    check_pins("reset", 7'h00, 1'b0, 4'b0000);
    chk_pend("reset", 1'b0);
    chk("reset frame", frm, 1'b0);
    chk("reset frame_n", frm_n, 1'b0);

    // Free scan after release: each digit for 4 clocks, frame pulse on clock 17.
    rst_n = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      check_pins($sformatf("scan c%0d", c), exp_seg(16'h0, (c - 1) / 4), 1'b0, 4'b0001 << ((c - 1) / 4));
      chk($sformatf("scan c%0d frame", c), frm, 1'b0);
    end
    @(negedge clk);
    chk("scan c17 frame", frm, 1'b1);
    chk("scan c17 an", an, 4'b0001);

    // Mid-frame load waits for the boundary.
    @(negedge clk);
    load = 1'b1; val = 16'h1234; dpi = 4'b0100;
    @(negedge clk);
    load = 1'b0;
    chk_pend("load1234", 1'b1);
    repeat (5) @(negedge clk);
    chk_pend("load1234 hold", 1'b1);
    wait_frame("load1234");
    chk_pend("load1234 commit", 1'b0);
    push_frame(16'h1234, 4'b0100);
    check_frame("f1234");

    // Last write wins.
    @(negedge clk);
    load = 1'b1; val = 16'hAAAA; dpi = 4'b1111;
    @(negedge clk);
    load = 1'b0;
    repeat (3) @(negedge clk);
    load = 1'b1; val = 16'hBEEF; dpi = 4'b0000;
    @(negedge clk);
    load = 1'b0;
    chk_pend("beef", 1'b1);
    wait_frame("beef");
    push_frame(16'hBEEF, 4'b0000);
    check_frame("fBEEF");

    // Load on the boundary edge bypasses pending.
    repeat (14) @(negedge clk);
    load = 1'b1; val = 16'h00C5; dpi = 4'b0000;
    @(negedge clk);
    load = 1'b0;
    chk_pend("bnd load", 1'b0);
    wait_frame("bnd");
    chk_pend("bnd after", 1'b0);
    push_frame(16'h00C5, 4'b0000);
    check_frame("f00C5");

    // Leading-zero patterns, decimal point on an upper digit.
    @(negedge clk);
    load = 1'b1; val = 16'h0005; dpi = 4'b0001;
    @(negedge clk);
    load = 1'b0;
    wait_frame("z5");
    push_frame(16'h0005, 4'b0001);
    check_frame("f0005");
    @(negedge clk);
    load = 1'b1; val = 16'h0000; dpi = 4'b1000;
    @(negedge clk);
    load = 1'b0;
    wait_frame("z0");
    push_frame(16'h0000, 4'b1000);
    check_frame("f0000");

    // Reset mid-frame with a load pending discards it.
    repeat (3) @(negedge clk);
    load = 1'b1; val = 16'h5678; dpi = 4'b1111;
    @(negedge clk);
    load = 1'b0;
    chk_pend("pre-rst", 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_pins("mid rst", 7'h00, 1'b0, 4'b0000);
    chk_pend("mid rst", 1'b0);
    chk("mid rst frame", frm, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_pins("post rst", 7'h3F, 1'b0, 4'b0001);
    chk_pend("post rst", 1'b0);
    wait_frame("post rst");
    push_frame(16'h0000, 4'b0000);
    check_frame("fpost");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
